// File: rtl/board_scanner.sv
// Row-major sweep of the game board through a 1-cycle-latency read port,
// reporting win, first cell differing from (0,0) and a per-colour histogram.
// state  | meaning
// IDLE   | waiting for start_i; results from last scan held
// SCAN   | issuing one read per cycle, row-major
// DRAIN  | consuming the final read return
// FINISH | publishing won, pulsing done, dropping busy
module board_scanner #(
  parameter int MAX_SIZE = 26,
  parameter int COLOR_W  = 3,
  parameter int CNT_W    = 10
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            start_i,
  input  logic [4:0]                      size_i,
  output logic [4:0]                      rd_row_o,
  output logic [4:0]                      rd_col_o,
  output logic                            rd_en_o,
  input  logic [COLOR_W-1:0]              rd_data_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            won_o,
  output logic                            size_err_o,
  output logic [4:0]                      diff_row_o,
  output logic [4:0]                      diff_col_o,
  output logic [(2**COLOR_W)*CNT_W-1:0]   color_counts_o
);
  localparam int         NBINS = 2**COLOR_W;
  localparam logic [4:0] NONE  = 5'd31;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t             state_q;
  logic [4:0]         size_q, row_q, col_q, vrow_q, vcol_q;
  logic [4:0]         diff_row_q, diff_col_q;
  logic               rd_en_q, valid_q, busy_q, done_q, won_q, size_err_q;
  logic [COLOR_W-1:0] ref_q;
  logic [CNT_W-1:0]   cnt_q [NBINS];

  logic [4:0] last_d, row_d, col_d;
  logic       at_last_col_d, at_end_d;

  always_comb begin
    last_d        = size_q - 5'd1;
    at_last_col_d = (col_q == last_d);
    at_end_d      = at_last_col_d && (row_q == last_d);
    col_d         = at_last_col_d ? 5'd0 : col_q + 5'd1;
    row_d         = at_last_col_d ? row_q + 5'd1 : row_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      size_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      vrow_q     <= '0;
      vcol_q     <= '0;
      diff_row_q <= NONE;
      diff_col_q <= NONE;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      won_q      <= 1'b0;
      size_err_q <= 1'b0;
      ref_q      <= '0;
      for (int c = 0; c < NBINS; c++) cnt_q[c] <= '0;
    end else begin
      // Return pipeline: valid and address copy trail the issued read by one cycle.
      valid_q <= rd_en_q;
      vrow_q  <= row_q;
      vcol_q  <= col_q;
      done_q  <= 1'b0;
      if (valid_q) begin
        if (vrow_q == 5'd0 && vcol_q == 5'd0) begin
          ref_q <= rd_data_i;
        end else if (rd_data_i != ref_q && diff_row_q == NONE) begin
          diff_row_q <= vrow_q;
          diff_col_q <= vcol_q;
        end
        cnt_q[rd_data_i] <= cnt_q[rd_data_i] + CNT_W'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            size_q     <= size_i;
            won_q      <= 1'b0;
            diff_row_q <= NONE;
            diff_col_q <= NONE;
            busy_q     <= 1'b1;
            row_q      <= '0;
            col_q      <= '0;
            for (int c = 0; c < NBINS; c++) cnt_q[c] <= '0;
            if (size_i == 5'd0 || size_i > 5'(MAX_SIZE)) begin
              size_err_q <= 1'b1;
              state_q    <= FINISH;
            end else begin
              size_err_q <= 1'b0;
              rd_en_q    <= 1'b1;
              state_q    <= SCAN;
            end
          end
        end
        SCAN: begin
          if (at_end_d) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            row_q <= row_d;
            col_q <= col_d;
          end
        end
        DRAIN: state_q <= FINISH;
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          won_q   <= !size_err_q && (diff_row_q == NONE);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_row_o   = row_q;
  assign rd_col_o   = col_q;
  assign rd_en_o    = rd_en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign won_o      = won_q;
  assign size_err_o = size_err_q;
  assign diff_row_o = diff_row_q;
  assign diff_col_o = diff_col_q;

  for (genvar c = 0; c < NBINS; c++) begin : g_cnt
    assign color_counts_o[c*CNT_W +: CNT_W] = cnt_q[c];
  end

endmodule
